// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, FSM state types and the beat address/burst legality check.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;

  // WRAP is not supported and 2'b11 is reserved: both fail every beat.
  function automatic logic beat_err(input logic [31:0] addr, input logic [1:0] burst,
                                    input logic [31:0] base, input int unsigned depth);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return off[32] || (off[31:0] >= 32'(depth) * 32'd8) ||
           (burst == BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/sram_2p.sv
// DEPTH x 64 SRAM: byte-enable write port and registered read port; q holds when re is low.
// A read and write to the same word in one cycle returns the old contents.
module sram_2p #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wstrb,
  input  logic [63:0]   wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [63:0]   q
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re) q <= mem[ra];
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) mem[wa][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: first R beat RLAT cycles after AR, then one beat per cycle while rready;
// B one cycle after the last W beat. Valids hold until handshake; new AR/AW only once idle.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned RLAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int unsigned AW = $clog2(DEPTH);

  rstate_t     r_state, r_next;
  logic [31:0] r_addr, r_addr_nxt, rd_addr;
  logic [7:0]  r_cnt, r_wait;
  logic [3:0]  r_id;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_err, rd_en;
  logic [63:0] rd_q;

  wstate_t     w_state, w_next;
  logic [31:0] w_addr, w_addr_nxt;
  logic [7:0]  w_cnt;
  logic [3:0]  w_id;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        b_err, w_hs, w_beat_err;

  // ---------------- read channel ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid) r_next = R_WAIT;
      R_WAIT:  if (r_wait == 8'd0) r_next = R_DATA;
      R_DATA:  if (rready && r_cnt == 8'd0) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
    rlast   = rvalid && (r_cnt == 8'd0);
    rresp   = (rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
    rdata   = (rvalid && !r_err) ? rd_q : 64'd0;
    rid     = r_id;
  end

  // The SRAM is read only when a new beat is due, so rd_q/r_err hold during backpressure.
  assign r_addr_nxt = (r_burst == BURST_FIXED) ? r_addr : r_addr + (32'd1 << r_size);
  assign rd_en      = (r_state == R_WAIT) || (rvalid && rready && !rlast);
  assign rd_addr    = (r_state == R_DATA) ? r_addr_nxt : r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_id    <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
    end else begin
      if (arvalid && arready) begin
        r_addr  <= araddr;
        r_cnt   <= arlen;
        r_wait  <= 8'(RLAT - 1);
        r_id    <= arid;
        r_size  <= arsize;
        r_burst <= arburst;
      end
      if (r_state == R_WAIT && r_wait != 8'd0) r_wait <= r_wait - 8'd1;
      if (rvalid && rready) begin
        r_cnt  <= r_cnt - 8'd1;
        r_addr <= r_addr_nxt;
      end
      if (rd_en) r_err <= beat_err(rd_addr, r_burst, BASE, DEPTH);
    end
  end

  // ---------------- write channel ----------------
  assign w_hs       = wvalid && wready;
  assign w_beat_err = beat_err(w_addr, w_burst, BASE, DEPTH);
  assign w_addr_nxt = (w_burst == BURST_FIXED) ? w_addr : w_addr + (32'd1 << w_size);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (awvalid) w_next = W_DATA;
      W_DATA:  if (w_hs && w_cnt == 8'd0) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
    bresp   = (bvalid && b_err) ? RESP_SLVERR : RESP_OKAY;
    bid     = w_id;
  end

  // Beat count is ours; a wlast that disagrees with it poisons the response only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr  <= '0;
      w_cnt   <= '0;
      w_id    <= '0;
      w_size  <= '0;
      w_burst <= '0;
      b_err   <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        w_addr  <= awaddr;
        w_cnt   <= awlen;
        w_id    <= awid;
        w_size  <= awsize;
        w_burst <= awburst;
        b_err   <= 1'b0;
      end
      if (w_hs) begin
        w_cnt  <= w_cnt - 8'd1;
        w_addr <= w_addr_nxt;
        b_err  <= b_err | w_beat_err | (wlast != (w_cnt == 8'd0));
      end
    end
  end

  sram_2p #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk   (clk),
    .we    (w_hs && !w_beat_err),
    .wa    (w_addr[AW+2:3]),
    .wstrb (wstrb),
    .wd    (wdata),
    .re    (rd_en),
    .ra    (rd_addr[AW+2:3]),
    .q     (rd_q)
  );

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized AXI bursts against a word-array model of the memory window; a negedge
// monitor checks every R and B beat against queued expectations, tasks check timing.
module tb_axi_mem_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 4096;
  localparam int unsigned RLAT  = 1;

  logic        clk, rst;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awid, bid, arid, rid;
  logic [7:0]  awlen, wstrb, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, bresp, arburst, rresp;
  logic [63:0] wdata, rdata;
  logic        arvalid, arready, rvalid, rready, rlast;

  axi_mem_slave #(.BASE(BASE), .DEPTH(DEPTH), .RLAT(RLAT)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {logic [63:0] d; logic [1:0] resp; logic last; logic [3:0] id;} rbeat_t;
  typedef struct {logic [1:0] resp; logic [3:0] id;} bexp_t;

  rbeat_t      exp_r[$];
  bexp_t       exp_b[$];
  logic [63:0] mem_m [DEPTH];
  logic [63:0] wd_a [256];
  logic [7:0]  ws_a [256];
  int          total = 0;
  int          bad = 0;
  logic [63:0] cap_rdata;
  logic [1:0]  cap_rresp, cap_bresp;
  logic        cap_rlast;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit m_err(input longint a, input logic [1:0] bu);
    return (a < longint'(BASE)) || (a >= longint'(BASE) + longint'(DEPTH) * 8) || (bu >= 2'd2);
  endfunction

  function automatic int m_idx(input longint a);
    return int'((a - longint'(BASE)) >>> 3);
  endfunction

  // Monitor: every cycle a valid is up, its payload must equal the queue head.
  initial begin
    bit must_rv, must_bv;
    must_rv = 0;
    must_bv = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        must_rv = 0;
        must_bv = 0;
      end else begin
        if (must_rv) chk("r_hold_or_bubble", 64'(rvalid), 64'd1);
        must_rv = 0;
        if (rvalid) begin
          chk("ar_busy", 64'(arready), 64'd0);
          if (exp_r.size() == 0) chk("r_spurious", 64'(rvalid), 64'd0);
          else begin
            chk("rdata", rdata, exp_r[0].d);
            chk("rresp", 64'(rresp), 64'(exp_r[0].resp));
            chk("rlast", 64'(rlast), 64'(exp_r[0].last));
            chk("rid", 64'(rid), 64'(exp_r[0].id));
            must_rv = !(rready && exp_r[0].last);
            if (rready) void'(exp_r.pop_front());
          end
        end
        if (must_bv) chk("b_hold", 64'(bvalid), 64'd1);
        must_bv = 0;
        if (bvalid) begin
          chk("aw_busy", 64'(awready), 64'd0);
          if (exp_b.size() == 0) chk("b_spurious", 64'(bvalid), 64'd0);
          else begin
            chk("bresp", 64'(bresp), 64'(exp_b[0].resp));
            chk("bid", 64'(bid), 64'(exp_b[0].id));
            must_bv = !bready;
            if (bready) void'(exp_b.pop_front());
          end
        end
      end
    end
  end

  // mode: 0 rready always high, 1 random stalls, 2 low for three cycles on beat 1
  task automatic do_read(input logic [31:0] a, input int len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [3:0] id, input int mode);
    longint ma;
    int     cyc;
    rbeat_t b;
    @(posedge clk);
    #1;
    ma = longint'(a);
    for (int i = 0; i <= len; i++) begin
      b.resp = m_err(ma, bu) ? 2'b10 : 2'b00;
      b.d    = m_err(ma, bu) ? 64'd0 : mem_m[m_idx(ma)];
      b.last = (i == len);
      b.id   = id;
      exp_r.push_back(b);
      if (bu != 2'b00) ma += longint'(1) << sz;
    end
    araddr = a; arlen = 8'(len); arsize = sz; arburst = bu; arid = id; arvalid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!arready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("ar_ready", 64'(arready), 64'd1);
    @(posedge clk);
    #1 arvalid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rvalid && cyc < 50);
    chk("r_latency", 64'(cyc), 64'(RLAT + 1));
    cap_rdata = rdata; cap_rresp = rresp; cap_rlast = rlast;
    cyc = 0;
    while (exp_r.size() != 0 && cyc < 2000) begin
      @(posedge clk);
      #1;
      case (mode)
        1:       rready = ($urandom_range(0, 3) != 0);
        2:       rready = !(cyc >= 1 && cyc <= 3);
        default: rready = 1'b1;
      endcase
      cyc++;
    end
    rready = 1'b0;
    if (exp_r.size() != 0) begin
      chk("r_drain", 64'(exp_r.size()), 64'd0);
      exp_r.delete();
    end
  endtask

  // wmode: 0 correct wlast, 1 wlast on first beat, 2 wlast never set
  task automatic do_write(input logic [31:0] a, input int len, input logic [2:0] sz,
                          input logic [1:0] bu, input logic [3:0] id, input int wmode,
                          input int bstall, input bit gaps);
    longint ma;
    int     cyc;
    bit     err, e;
    logic   wl;
    bexp_t  be;
    @(posedge clk);
    #1;
    awaddr = a; awlen = 8'(len); awsize = sz; awburst = bu; awid = id; awvalid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!awready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("aw_ready", 64'(awready), 64'd1);
    @(posedge clk);
    #1 awvalid = 1'b0;
    @(negedge clk);
    ma = longint'(a);
    err = 0;
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(negedge clk);
      end
      wl = (wmode == 2) ? 1'b0 : (wmode == 1) ? (i == 0) : (i == len);
      wdata = wd_a[i]; wstrb = ws_a[i]; wlast = wl; wvalid = 1'b1;
      chk("w_ready", 64'(wready), 64'd1);
      e = m_err(ma, bu);
      if (!e) begin
        for (int k = 0; k < 8; k++)
          if (ws_a[i][k]) mem_m[m_idx(ma)][8*k +: 8] = wd_a[i][8*k +: 8];
      end
      err = err | e | (wl != (i == len));
      if (bu != 2'b00) ma += longint'(1) << sz;
      if (i == len) begin
        be.resp = err ? 2'b10 : 2'b00;
        be.id   = id;
        exp_b.push_back(be);
      end
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("b_latency", 64'(bvalid), 64'd1);
    cap_bresp = bresp;
    repeat (bstall + 1) @(posedge clk);
    #1 bready = 1'b1;
    @(posedge clk);
    #1 bready = 1'b0;
    @(negedge clk);
    chk("aw_after_b", 64'(awready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    int          rl;
    logic [2:0]  rs;
    logic [1:0]  rb;
    rst = 1'b1;
    {awvalid, wvalid, bready, arvalid, rready, wlast} = '0;
    {awaddr, araddr, awid, arid, awlen, arlen, awsize, arsize, awburst, arburst} = '0;
    wdata = '0; wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_resp", {60'd0, rresp, bresp}, 64'd0);
    chk("rst_ids", {56'd0, rid, bid}, 64'd0);
    rst = 1'b0;

    // Preload words 0..63 with a recognisable pattern, then word 0 with the fetch value.
    for (int i = 0; i < 64; i++) begin wd_a[i] = 64'hA5A5_0000_0000_0000 | 64'(i); ws_a[i] = 8'hFF; end
    do_write(BASE, 63, 3'd3, 2'b01, 4'd1, 0, 0, 0);
    wd_a[0] = 64'h1122_3344_5566_7788;
    do_write(BASE, 0, 3'd3, 2'b01, 4'd2, 0, 0, 0);

    do_read(BASE, 0, 3'd3, 2'b01, 4'd3, 0);
    chk("single_rdata", cap_rdata, 64'h1122_3344_5566_7788);
    chk("single_rlast", 64'(cap_rlast), 64'd1);
    chk("single_rresp", 64'(cap_rresp), 64'd0);

    do_read(BASE + 32'd4, 1, 3'd2, 2'b01, 4'd4, 0);
    chk("fetch_beat0", cap_rdata, 64'h1122_3344_5566_7788);
    chk("fetch_beat0_last", 64'(cap_rlast), 64'd0);

    wd_a[0] = 64'hAAAA_BBBB_CCCC_DDDD; ws_a[0] = 8'h0F;
    wd_a[1] = 64'h1;                   ws_a[1] = 8'hFF;
    do_write(BASE + 32'd40, 1, 3'd3, 2'b01, 4'd5, 0, 0, 0);
    chk("wburst_bresp", 64'(cap_bresp), 64'd0);
    do_read(BASE + 32'd40, 1, 3'd3, 2'b01, 4'd6, 0);
    chk("wburst_readback", cap_rdata, 64'hA5A5_0000_CCCC_DDDD);

    do_read(BASE + 32'(DEPTH * 8), 0, 3'd3, 2'b01, 4'd7, 0);
    chk("oor_rresp", 64'(cap_rresp), 64'd2);
    chk("oor_rdata", cap_rdata, 64'd0);
    wd_a[0] = '1; ws_a[0] = 8'hFF;
    do_write(BASE + 32'(DEPTH * 8), 0, 3'd3, 2'b01, 4'd8, 0, 0, 0);
    chk("oor_bresp", 64'(cap_bresp), 64'd2);
    do_read(BASE, 0, 3'd3, 2'b01, 4'd9, 0);
    chk("oor_mem_kept", cap_rdata, 64'h1122_3344_5566_7788);
    do_read(BASE - 32'd8, 0, 3'd3, 2'b01, 4'd1, 0);
    chk("below_base_rresp", 64'(cap_rresp), 64'd2);

    wd_a[0] = 64'h7E57_0000_0000_0FFF; ws_a[0] = 8'hFF;
    do_write(BASE + 32'((DEPTH - 1) * 8), 0, 3'd3, 2'b01, 4'd2, 0, 0, 0);
    do_read(BASE + 32'((DEPTH - 1) * 8), 2, 3'd3, 2'b01, 4'd3, 0);

    do_read(BASE + 32'd64, 3, 3'd3, 2'b01, 4'd8, 2);
    for (int i = 0; i < 2; i++) begin wd_a[i] = {$urandom, $urandom}; ws_a[i] = 8'hFF; end
    do_write(BASE + 32'd80, 1, 3'd3, 2'b01, 4'd11, 0, 5, 0);

    for (int i = 0; i < 3; i++) begin wd_a[i] = {$urandom, $urandom}; ws_a[i] = 8'hF0; end
    do_write(BASE + 32'd96, 2, 3'd3, 2'b01, 4'd12, 1, 0, 0);
    chk("wlast_early_bresp", 64'(cap_bresp), 64'd2);
    do_read(BASE + 32'd96, 2, 3'd3, 2'b01, 4'd12, 0);

    // Reset after the first of four write beats.
    @(posedge clk);
    #1;
    awaddr = BASE + 32'd160; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awid = 4'd9; awvalid = 1'b1;
    @(negedge clk);
    chk("rt_aw_ready", 64'(awready), 64'd1);
    @(posedge clk);
    #1 awvalid = 1'b0;
    @(negedge clk);
    wdata = 64'h0BAD_F00D_0000_0001; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
    mem_m[20] = 64'h0BAD_F00D_0000_0001;
    @(negedge clk);
    rst = 1'b1;
    wvalid = 1'b0;
    #1;
    chk("rt_awready_async", 64'(awready), 64'd1);
    chk("rt_wready_async", 64'(wready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rt_no_b", 64'(bvalid), 64'd0);
    end
    do_read(BASE + 32'd160, 0, 3'd3, 2'b01, 4'd10, 0);
    chk("rt_beat1_kept", cap_rdata, 64'h0BAD_F00D_0000_0001);

    for (int it = 0; it < 40; it++) begin
      ra = BASE + 32'($urandom_range(0, 447));
      rl = $urandom_range(0, 7);
      rs = 3'($urandom_range(0, 3));
      rb = ($urandom_range(0, 9) == 0) ? 2'b10 : (($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= rl; i++) begin
          wd_a[i] = {$urandom, $urandom};
          ws_a[i] = 8'($urandom_range(0, 255));
        end
        do_write(ra, rl, rs, rb, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0) ? 2 : 0, $urandom_range(0, 3), 1'b1);
      end else begin
        do_read(ra, rl, rs, rb, 4'($urandom_range(0, 15)), 1);
      end
    end

    repeat (3) @(negedge clk);
    chk("r_queue_empty", 64'(exp_r.size()), 64'd0);
    chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
